logic_sched: RTL

LOGIC_SCHED -- requirements
Module: logic_sched

---
 rtl/logic_sched.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/logic_sched.sv
// Round-robin scheduler sharing one logic unit among 4 requesters (LOGIC_SCHED_FIXED_PRIO_EN selects fixed priority).
// Latency: grant in cycle N, rsp_valid in N+2; back-to-back grants are spaced 3 cycles apart.
// Backpressure: the response is held stable in RESP until rsp_ready; no new grant is issued meanwhile.

module logic_sched_lu #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] y,
    output logic [4:0]       flags
);
    always_comb begin
        y = '0;
        case (op)
            3'b000:  y = a & b;
            3'b001:  y = a | b;
            3'b010:  y = ~(a | b);
            3'b100:  y = ~a;
            3'b101:  y = ~b;
            3'b110:  y = a ^ b;
            3'b111:  y = ~(a ^ b);
            default: y = '0;  // 3'b011 is a legal no-op returning zero
        endcase
    end

    assign flags = {a == '0, b == '0, a == b, a > b, a < b};
endmodule

module logic_sched #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         req_valid,
    output logic [3:0]         req_ready,
    input  logic [4*WIDTH-1:0] req_a,
    input  logic [4*WIDTH-1:0] req_b,
    input  logic [11:0]        req_op,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [1:0]         rsp_id,
    output logic [WIDTH-1:0]   rsp_data,
    output logic [4:0]         rsp_flags,
    output logic               busy,
    output logic [15:0]        op_count
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state;
    logic [WIDTH-1:0] lat_a;
    logic [WIDTH-1:0] lat_b;
    logic [2:0]       lat_op;
    logic [1:0]       lat_id;
    logic [1:0]       gnt_idx;
    logic [WIDTH-1:0] lu_y;
    logic [4:0]       lu_flags;

`ifdef LOGIC_SCHED_FIXED_PRIO_EN
    always_comb begin
        gnt_idx = '0;
        for (int k = 3; k >= 0; k--) begin
            if (req_valid[k]) gnt_idx = 2'(k);
        end
    end
`else
    logic [1:0] ptr;
    logic [1:0] cand;

    // Walk from lowest to highest priority so the last hit (closest to ptr) wins.
    always_comb begin
        gnt_idx = '0;
        cand    = '0;
        for (int k = 3; k >= 0; k--) begin
            cand = ptr + 2'(k);
            if (req_valid[cand]) gnt_idx = cand;
        end
    end
`endif

    assign req_ready = (state == IDLE && !rst && |req_valid) ? (4'b0001 << gnt_idx) : 4'b0000;
    assign busy      = (state != IDLE);

    logic_sched_lu #(.WIDTH(WIDTH)) u_lu (
        .a     (lat_a),
        .b     (lat_b),
        .op    (lat_op),
        .y     (lu_y),
        .flags (lu_flags)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            rsp_flags <= '0;
            op_count  <= '0;
            lat_a     <= '0;
            lat_b     <= '0;
            lat_op    <= '0;
            lat_id    <= '0;
`ifndef LOGIC_SCHED_FIXED_PRIO_EN
            ptr       <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        lat_a  <= req_a[gnt_idx*WIDTH +: WIDTH];
                        lat_b  <= req_b[gnt_idx*WIDTH +: WIDTH];
                        lat_op <= req_op[gnt_idx*3 +: 3];
                        lat_id <= gnt_idx;
`ifndef LOGIC_SCHED_FIXED_PRIO_EN
                        ptr    <= gnt_idx + 2'd1;
`endif
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data  <= lu_y;
                    rsp_flags <= lu_flags;
                    rsp_id    <= lat_id;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                        if (op_count != 16'hFFFF) op_count <= op_count + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
